// File: rtl/allpass_pkg.sv
// Shared types and arithmetic helpers for the 2x allpass half-band interpolator.
package allpass_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT0 = 2'd2,
        OUT1 = 2'd3
    } state_t;

    // Round-half-up bias, 2^(width-2), added to the product before the WIDTH-1 fraction bits are dropped
    function automatic logic signed [63:0] roundBias(input int width);
        return 64'sd1 <<< (width - 2);
    endfunction

    // Clip a wide signed value into the signed range of a width-bit word
    function automatic logic signed [63:0] satToWidth(input logic signed [63:0] value, input int width);
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
        minVal = -(64'sd1 <<< (width - 1));
        if (value > maxVal) begin
            return maxVal;
        end else if (value < minVal) begin
            return minVal;
        end
        return value;
    endfunction

    // Bit offset of section k inside a packed coefficient bus
    function automatic int coefLsb(input int section, input int width);
        return section * width;
    endfunction

endpackage

// File: rtl/allpass_interp2_if.sv
// Sample-in / sample-out handshake bus of the allpass interpolator, plus the packed coefficient inputs.
interface allpass_interp2_if #(
    parameter int WIDTH = 16,
    parameter int N     = 2
);
    logic signed [WIDTH-1:0] din;
    logic                    in_valid;
    logic                    in_ready;
    logic [N*WIDTH-1:0]      c0;
    logic [N*WIDTH-1:0]      c1;
    logic signed [WIDTH-1:0] dout;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output din,
        output in_valid,
        output c0,
        output c1,
        output out_ready,
        input  in_ready,
        input  dout,
        input  out_valid
    );

    modport slave (
        input  din,
        input  in_valid,
        input  c0,
        input  c1,
        input  out_ready,
        output in_ready,
        output dout,
        output out_valid
    );
endinterface

// File: rtl/allpass_mac.sv
// Single first-order allpass section, purely combinational: y = xprev + a*(x - yprev), saturated.
module allpass_mac
    import allpass_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] xPrev_i,
    input  logic signed [WIDTH-1:0] yPrev_i,
    input  logic signed [WIDTH-1:0] a_i,
    output logic signed [WIDTH-1:0] y_o
);
    localparam int DW = WIDTH + 1;
    localparam int PW = 2 * WIDTH + 1;
    localparam int RW = WIDTH + 2;
    localparam int SW = WIDTH + 3;

    logic signed [DW-1:0] diff;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] biased;
    logic signed [PW-1:0] shifted;
    logic signed [RW-1:0] rounded;
    logic signed [SW-1:0] sum;
    logic signed [63:0]   clipped;

    // Difference at WIDTH+1 bits, full product, round half up, add xprev, then clip to WIDTH bits
    always_comb begin
        diff    = DW'(x_i) - DW'(yPrev_i);
        product = PW'(a_i) * PW'(diff);
        biased  = product + PW'(roundBias(WIDTH));
        shifted = biased >>> (WIDTH - 1);
        rounded = RW'(shifted);
        sum     = SW'(xPrev_i) + SW'(rounded);
        clipped = satToWidth(64'(sum), WIDTH);
        y_o     = WIDTH'(clipped);
    end

endmodule

// File: rtl/allpass_interp2.sv
// 2x polyphase allpass interpolator: one shared section datapath walks both branches, then emits A0 and A1.
module allpass_interp2
    import allpass_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 2
) (
    input logic              clk,
    input logic              rst,
    allpass_interp2_if.slave bus
);
    localparam int            S       = 2 * N;
    localparam int            KW      = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(S - 1);
    localparam logic [KW-1:0] K_SPLIT = KW'(N);

    state_t                  state_q;
    state_t                  state_d;
    logic [KW-1:0]           k_q;
    logic [KW-1:0]           k_d;
    logic signed [WIDTH-1:0] din_q;
    logic signed [WIDTH-1:0] coef_q  [S];
    logic signed [WIDTH-1:0] xPrev_q [S];
    logic signed [WIDTH-1:0] yPrev_q [S];

    logic                    accept;
    logic                    inReady;
    logic                    outValid;
    logic signed [WIDTH-1:0] doutSel;
    logic                    firstSection;
    logic [KW-1:0]           prevIdx;
    logic signed [WIDTH-1:0] macX;
    logic signed [WIDTH-1:0] macY;

    // Section 0 of a branch consumes the latched sample; later sections consume the y their predecessor wrote last cycle
    always_comb begin
        firstSection = (k_q == '0) || (k_q == K_SPLIT);
        prevIdx      = (k_q == '0) ? '0 : k_q - KW'(1);
        macX         = firstSection ? din_q : yPrev_q[prevIdx];
    end

    allpass_mac #(
        .WIDTH(WIDTH)
    ) u_mac (
        .x_i     (macX),
        .xPrev_i (xPrev_q[k_q]),
        .yPrev_i (yPrev_q[k_q]),
        .a_i     (coef_q[k_q]),
        .y_o     (macY)
    );

    // Next state, section counter and handshake outputs; dout is forced to zero outside the output states
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        inReady  = 1'b0;
        outValid = 1'b0;
        doutSel  = '0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                inReady = !rst;
                accept  = bus.in_valid && !rst;
                if (accept) begin
                    state_d = CALC;
                    k_d     = '0;
                end
            end
            CALC: begin
                if (k_q == K_LAST) begin
                    state_d = OUT0;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            OUT0: begin
                outValid = 1'b1;
                doutSel  = yPrev_q[N-1];
                if (bus.out_ready) begin
                    state_d = OUT1;
                end
            end
            OUT1: begin
                outValid = 1'b1;
                doutSel  = yPrev_q[S-1];
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and section counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Latch sample and coefficients at accept; write back one section's xprev/yprev per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            for (int i = 0; i < S; i++) begin
                coef_q[i]  <= '0;
                xPrev_q[i] <= '0;
                yPrev_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                din_q <= bus.din;
                for (int i = 0; i < N; i++) begin
                    coef_q[i]     <= bus.c0[coefLsb(i, WIDTH) +: WIDTH];
                    coef_q[N + i] <= bus.c1[coefLsb(i, WIDTH) +: WIDTH];
                end
            end
            if (state_q == CALC) begin
                xPrev_q[k_q] <= macX;
                yPrev_q[k_q] <= macY;
            end
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.dout      = doutSel;

endmodule

// File: tb/tb_allpass_interp2.sv
// Self-checking bench for allpass_interp2: an N=2 instance (A) and an N=1 instance (B) fed from one clock.
module tb_allpass_interp2;
    localparam int W     = 16;
    localparam int NA    = 2;
    localparam int NB    = 1;
    localparam int LAT_A = 2 * NA + 1;
    localparam int PER_A = 2 * NA + 3;
    localparam int LAT_B = 2 * NB + 1;

    typedef struct {
        logic         sel;
        logic         resetFirst;
        logic [W-1:0] din;
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
    } vec_t;

    logic         clk;
    logic         rstA;
    logic         rstB;
    int           checks;
    int           errors;
    logic [W-1:0] expQA[$];
    logic [W-1:0] expQB[$];
    vec_t         tbl[9];
    logic [W-1:0] d[5];

    allpass_interp2_if #(.WIDTH(W), .N(NA)) busA ();
    allpass_interp2_if #(.WIDTH(W), .N(NB)) busB ();

    allpass_interp2 #(.WIDTH(W), .N(NA)) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (busA.slave)
    );

    allpass_interp2 #(.WIDTH(W), .N(NB)) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    function automatic logic readyOf(input logic sel);
        return sel ? busB.in_ready : busA.in_ready;
    endfunction

    task automatic applyStimulus(input logic sel, input logic [W-1:0] din, input logic [W-1:0] a0,
                                 input logic [W-1:0] a1, input logic [W-1:0] e0, input logic [W-1:0] e1,
                                 input logic push);
        int guard;
        guard = 0;
        while (readyOf(sel) !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput(sel ? "B in_ready before drive" : "A in_ready before drive", {15'd0, readyOf(sel)}, 16'd1);
        if (sel) begin
            busB.din      = din;
            busB.c0       = a0;
            busB.c1       = a1;
            busB.in_valid = 1'b1;
            if (push) begin
                expQB.push_back(e0);
                expQB.push_back(e1);
            end
        end else begin
            busA.din      = din;
            busA.c0       = {a0, a0};
            busA.c1       = {a1, a1};
            busA.in_valid = 1'b1;
            if (push) begin
                expQA.push_back(e0);
                expQA.push_back(e1);
            end
        end
        tick();
        busA.in_valid = 1'b0;
        busB.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input logic sel);
        int guard;
        guard = 0;
        while ((sel ? expQB.size() : expQA.size()) != 0 && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput(sel ? "B drain" : "A drain", 16'(sel ? expQB.size() : expQA.size()), 16'd0);
        if (sel) expQB.delete();
        else expQA.delete();
        repeat (3) tick();
    endtask

    task automatic resetDut(input logic sel);
        if (sel) rstB = 1'b1;
        else rstA = 1'b1;
        tick();
        if (sel) begin
            checkOutput("B in_ready in reset", {15'd0, busB.in_ready}, 16'd0);
            checkOutput("B out_valid in reset", {15'd0, busB.out_valid}, 16'd0);
            checkOutput("B dout in reset", busB.dout, 16'd0);
            rstB = 1'b0;
        end else begin
            checkOutput("A in_ready in reset", {15'd0, busA.in_ready}, 16'd0);
            checkOutput("A out_valid in reset", {15'd0, busA.out_valid}, 16'd0);
            checkOutput("A dout in reset", busA.dout, 16'd0);
            rstA = 1'b0;
        end
        tick();
        checkOutput(sel ? "B in_ready after reset" : "A in_ready after reset", {15'd0, readyOf(sel)}, 16'd1);
    endtask

    initial begin
        int c;
        checks        = 0;
        errors        = 0;
        rstA          = 1'b1;
        rstB          = 1'b1;
        busA.din      = '0;
        busA.in_valid = 1'b0;
        busA.c0       = '0;
        busA.c1       = '0;
        busA.out_ready = 1'b1;
        busB.din      = '0;
        busB.in_valid = 1'b0;
        busB.c0       = '0;
        busB.c1       = '0;
        busB.out_ready = 1'b1;

        // sel, resetFirst, din, a0, a1, exp0, exp1
        tbl[0] = '{1'b0, 1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[4] = '{1'b0, 1'b1, 16'd1000, 16'h4000, 16'h0000, 16'd250,  16'h0000};
        tbl[5] = '{1'b1, 1'b1, 16'd1000, 16'h4000, 16'h4000, 16'd500,  16'd500};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h4000, 16'h4000, 16'd750,  16'd750};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h4000, 16'h4000, 16'hFE89, 16'hFE89};
        tbl[8] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000};

        fork
            forever begin
                @(negedge clk);
                if (rstA === 1'b0 && busA.out_valid === 1'b1 && busA.out_ready === 1'b1) begin
                    checkOutput("A output pending", 16'(expQA.size() != 0), 16'd1);
                    if (expQA.size() != 0) checkOutput("A dout", busA.dout, expQA.pop_front());
                end
                if (rstB === 1'b0 && busB.out_valid === 1'b1 && busB.out_ready === 1'b1) begin
                    checkOutput("B output pending", 16'(expQB.size() != 0), 16'd1);
                    if (expQB.size() != 0) checkOutput("B dout", busB.dout, expQB.pop_front());
                end
            end
        join_none

        repeat (3) tick();
        checkOutput("A in_ready in reset", {15'd0, busA.in_ready}, 16'd0);
        checkOutput("A out_valid in reset", {15'd0, busA.out_valid}, 16'd0);
        checkOutput("A dout in reset", busA.dout, 16'd0);
        checkOutput("B in_ready in reset", {15'd0, busB.in_ready}, 16'd0);
        checkOutput("B out_valid in reset", {15'd0, busB.out_valid}, 16'd0);
        rstA = 1'b0;
        rstB = 1'b0;
        tick();
        checkOutput("A in_ready after reset", {15'd0, busA.in_ready}, 16'd1);
        checkOutput("B in_ready after reset", {15'd0, busB.in_ready}, 16'd1);

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].resetFirst) resetDut(tbl[i].sel);
            applyStimulus(tbl[i].sel, tbl[i].din, tbl[i].a0, tbl[i].a1, tbl[i].exp0, tbl[i].exp1, 1'b1);
            waitDrain(tbl[i].sel);
        end

        $display("[TB] backpressure in OUT0");
        resetDut(1'b0);
        applyStimulus(1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDrain(1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        waitDrain(1'b0);
        busA.out_ready = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 1'b1);
        c = 1;
        while (busA.out_valid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        checkOutput("A latency", 16'(c), 16'(LAT_A));
        for (int i = 0; i < 10; i++) begin
            busA.in_valid = i[0];
            busA.din      = 16'h7777;
            busA.c0       = 32'h7FFF7FFF;
            checkOutput("A out_valid stalled", {15'd0, busA.out_valid}, 16'd1);
            checkOutput("A dout stalled", busA.dout, 16'h4000);
            checkOutput("A in_ready stalled", {15'd0, busA.in_ready}, 16'd0);
            tick();
        end
        busA.in_valid  = 1'b0;
        busA.c0        = '0;
        busA.out_ready = 1'b1;
        waitDrain(1'b0);
        repeat (10) tick();
        checkOutput("A in_ready after stall", {15'd0, busA.in_ready}, 16'd1);

        $display("[TB] reset during CALC");
        applyStimulus(1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
        rstA = 1'b1;
        tick();
        checkOutput("A out_valid mid-CALC reset", {15'd0, busA.out_valid}, 16'd0);
        checkOutput("A dout mid-CALC reset", busA.dout, 16'd0);
        rstA = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, tbl[i].din, tbl[i].a0, tbl[i].a1, tbl[i].exp0, tbl[i].exp1, 1'b1);
            waitDrain(1'b0);
        end

        $display("[TB] coefficient change during CALC");
        resetDut(1'b1);
        applyStimulus(1'b1, 16'd1000, 16'h4000, 16'h4000, 16'd500, 16'd500, 1'b1);
        busB.c0  = 16'h7FFF;
        busB.c1  = 16'h8000;
        busB.din = 16'h1234;
        c = 1;
        while (busB.out_valid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        checkOutput("B latency", 16'(c), 16'(LAT_B));
        waitDrain(1'b1);
        busB.c0  = '0;
        busB.c1  = '0;
        busB.din = '0;

        $display("[TB] back-to-back inputs");
        resetDut(1'b0);
        busA.c0        = '0;
        busA.c1        = '0;
        busA.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) d[i] = 16'((i + 1) * 256);
        busA.din      = d[0];
        busA.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("A ready at accept", {15'd0, busA.in_ready}, 16'd1);
            if (i < 2) begin
                expQA.push_back(16'h0000);
                expQA.push_back(16'h0000);
            end else begin
                expQA.push_back(d[i-2]);
                expQA.push_back(d[i-2]);
            end
            tick();
            if (i < 4) busA.din = d[i+1];
            else busA.in_valid = 1'b0;
            c = 1;
            while (busA.out_valid !== 1'b1 && c < 20) begin
                tick();
                c++;
            end
            checkOutput("A back-to-back latency", 16'(c), 16'(LAT_A));
            while (busA.in_ready !== 1'b1 && c < 40) begin
                tick();
                c++;
            end
            checkOutput("A accept spacing", 16'(c), 16'(PER_A));
        end
        busA.in_valid = 1'b0;
        waitDrain(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
